// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - scan-code constants and FSM state encoding for the keyboard-to-ASCII stage
package kb_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EMIT    = 2'd2,
    ST_EMIT_LF = 2'd3
  } kb_state_e;

endpackage

// File: rtl/kb_ascii_lut.sv
// rtl/kb_ascii_lut.sv - combinational set-2 make code to ASCII lookup with shift/caps case rule
module kb_ascii_lut
  import kb_pkg::*;
(
  input  logic [7:0] scan,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] base;
  logic [7:0] alt;
  logic       letter;

  always_comb begin
    base = 8'h00;
    alt  = 8'h00;
    case (scan)
      8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";  8'h23: base = "d";
      8'h24: base = "e";  8'h2B: base = "f";  8'h34: base = "g";  8'h33: base = "h";
      8'h43: base = "i";  8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
      8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";  8'h4D: base = "p";
      8'h15: base = "q";  8'h2D: base = "r";  8'h1B: base = "s";  8'h2C: base = "t";
      8'h3C: base = "u";  8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
      8'h35: base = "y";  8'h1A: base = "z";
      8'h45: {base, alt} = "0)";
      8'h16: {base, alt} = "1!";
      8'h1E: {base, alt} = "2@";
      8'h26: {base, alt} = "3#";
      8'h25: {base, alt} = "4$";
      8'h2E: {base, alt} = "5%";
      8'h36: {base, alt} = "6^";
      8'h3D: {base, alt} = "7&";
      8'h3E: {base, alt} = "8*";
      8'h46: {base, alt} = "9(";
      8'h0E: {base, alt} = "`~";
      8'h4E: {base, alt} = "-_";
      8'h55: {base, alt} = "=+";
      8'h54: {base, alt} = "[{";
      8'h5B: {base, alt} = "]}";
      8'h5D: {base, alt} = {8'h5C, 8'h7C};
      8'h4C: {base, alt} = ";:";
      8'h52: {base, alt} = {8'h27, 8'h22};
      8'h41: {base, alt} = ",<";
      8'h49: {base, alt} = ".>";
      8'h4A: {base, alt} = "/?";
      8'h29: base = 8'h20;
      8'h0D: base = 8'h09;
      8'h66: base = 8'h08;
      SC_ENTER: base = ASCII_CR;
      default: base = 8'h00;
    endcase
  end

  assign letter = (base >= "a") && (base <= "z");

  always_comb begin
    if (letter) begin
      ascii = (shift ^ caps) ? (base - 8'h20) : base;
    end else begin
      ascii = (shift && (alt != 8'h00)) ? alt : base;
    end
  end

endmodule

// File: rtl/kb_ascii_ctrl.sv
// rtl/kb_ascii_ctrl.sv - scan-code FIFO to UART TX stage with break/ext/shift/caps tracking
// Define KB_CRLF_EN to follow every Enter 0x0D with a 0x0A write.
module kb_ascii_ctrl
  import kb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_scan_code,
  input  logic              i_scan_empty,
  output logic              o_scan_rd,
  input  logic              i_tx_full,
  output logic              o_tx_wr,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_shift,
  output logic              o_caps
);

  kb_state_e         state_q, state_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              brk_q, brk_d, ext_q, ext_d;
  logic              lsh_q, lsh_d, rsh_q, rsh_d;
  logic              caps_q, caps_d;
  logic              shift_q;
  logic [DATA_W-1:0] lut_ascii;

  kb_ascii_lut u_lut (
    .scan  (code_q),
    .shift (lsh_q | rsh_q),
    .caps  (caps_q),
    .ascii (lut_ascii)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      byte_q  <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      caps_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      byte_q  <= byte_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      caps_q  <= caps_d;
      shift_q <= lsh_d | rsh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    byte_d    = byte_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    lsh_d     = lsh_q;
    rsh_d     = rsh_q;
    caps_d    = caps_q;
    o_scan_rd = 1'b0;
    o_tx_wr   = 1'b0;
    o_tx_data = '0;
    case (state_q)
      ST_IDLE: begin
        // gating with reset keeps the pop strobe low while the FIFO head is visible during reset
        if (!i_scan_empty && i_reset) begin
          o_scan_rd = 1'b1;
          code_d    = i_scan_code;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (code_q == SC_BREAK) begin
          brk_d = 1'b1;
        end else if (code_q == SC_EXT) begin
          ext_d = 1'b1;
        end else if (ext_q) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else if (brk_q) begin
          brk_d = 1'b0;
          if (code_q == SC_LSHIFT) lsh_d = 1'b0;
          if (code_q == SC_RSHIFT) rsh_d = 1'b0;
        end else if (code_q == SC_LSHIFT) begin
          lsh_d = 1'b1;
        end else if (code_q == SC_RSHIFT) begin
          rsh_d = 1'b1;
        end else if (code_q == SC_CAPS) begin
          caps_d = ~caps_q;
        end else if (lut_ascii != '0) begin
          byte_d  = lut_ascii;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (!i_tx_full) begin
          o_tx_wr   = 1'b1;
          o_tx_data = byte_q;
`ifdef KB_CRLF_EN
          state_d   = (byte_q == ASCII_CR) ? ST_EMIT_LF : ST_IDLE;
`else
          state_d   = ST_IDLE;
`endif
        end
      end
`ifdef KB_CRLF_EN
      ST_EMIT_LF: begin
        if (!i_tx_full) begin
          o_tx_wr   = 1'b1;
          o_tx_data = ASCII_LF;
          state_d   = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_shift = shift_q;
  assign o_caps  = caps_q;

endmodule

// File: tb/tb_kb_ascii_ctrl.sv
// tb/tb_kb_ascii_ctrl.sv - self-checking bench for kb_ascii_ctrl (vector table, corner sequences, random vs model)
module tb_kb_ascii_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic [7:0] i_scan_code = 8'h00;
  logic       i_scan_empty = 1'b1;
  logic       i_tx_full = 1'b0;
  logic       o_scan_rd, o_tx_wr, o_shift, o_caps;
  logic [7:0] o_tx_data;

  always #5 i_clk = ~i_clk;

  kb_ascii_ctrl dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_scan_code  (i_scan_code),
    .i_scan_empty (i_scan_empty),
    .o_scan_rd    (o_scan_rd),
    .i_tx_full    (i_tx_full),
    .o_tx_wr      (o_tx_wr),
    .o_tx_data    (o_tx_data),
    .o_shift      (o_shift),
    .o_caps       (o_caps)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] fifo[$];
  logic [7:0] got[$];
  int         got_cyc[$];
  int         rd_cyc[$];
  logic [7:0] exp_q[$];

  logic m_brk, m_ext, m_ls, m_rs, m_caps;

  localparam logic [7:0] LC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
    8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] SC [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  localparam logic [7:0] MISC [10] = '{8'h29, 8'h0D, 8'h66, 8'h5A, 8'h76, 8'h05, 8'h75, 8'h12, 8'h59, 8'h58};
  localparam logic [7:0] YN [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  localparam logic [7:0] YS [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};

  typedef struct {
    int          n;
    logic [79:0] codes;
    int          ne;
    logic [47:0] exp;
    logic        shift;
    logic        caps;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    i_scan_empty = (fifo.size() == 0);
    i_scan_code  = i_scan_empty ? 8'h00 : fifo[0];
  endtask

  task automatic tick();
    logic pop;
    @(negedge i_clk);
    cyc++;
    pop = o_scan_rd;
    if (o_scan_rd) rd_cyc.push_back(cyc);
    if (o_tx_wr) begin
      got.push_back(o_tx_data);
      got_cyc.push_back(cyc);
    end
    @(posedge i_clk);
    #1;
    if (pop && fifo.size() > 0) void'(fifo.pop_front());
    drive();
  endtask

  task automatic push(input logic [7:0] c);
    fifo.push_back(c);
    drive();
  endtask

  task automatic do_reset();
    i_reset   = 1'b0;
    i_tx_full = 1'b0;
    fifo.delete();
    drive();
    tick();
    tick();
    got.delete();
    got_cyc.delete();
    rd_cyc.delete();
    i_reset = 1'b1;
  endtask

  task automatic wait_drain(input bit rnd_full, input int bound);
    for (int i = 0; i < bound && fifo.size() > 0; i++) begin
      if (rnd_full) i_tx_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    check("drain", fifo.size(), 0);
    i_tx_full = 1'b0;
    repeat (6) tick();
  endtask

  function automatic logic [7:0] m_ascii(input logic [7:0] c, input logic sh, input logic cp);
    string lo = "abcdefghijklmnopqrstuvwxyz";
    string dn = "0123456789";
    string ds = ")!@#$%^&*(";
    for (int i = 0; i < 26; i++) if (LC[i] == c) return (sh ^ cp) ? lo[i] - 8'd32 : lo[i];
    for (int i = 0; i < 10; i++) if (DC[i] == c) return sh ? ds[i] : dn[i];
    for (int i = 0; i < 11; i++) if (SC[i] == c) return sh ? YS[i] : YN[i];
    case (c)
      8'h29:   return 8'h20;
      8'h0D:   return 8'h09;
      8'h66:   return 8'h08;
      8'h5A:   return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input logic [7:0] c);
    logic [7:0] a;
    if (c == 8'hF0) m_brk = 1'b1;
    else if (c == 8'hE0) m_ext = 1'b1;
    else if (m_ext) begin m_ext = 1'b0; m_brk = 1'b0; end
    else if (m_brk) begin
      if (c == 8'h12) m_ls = 1'b0;
      if (c == 8'h59) m_rs = 1'b0;
      m_brk = 1'b0;
    end
    else if (c == 8'h12) m_ls = 1'b1;
    else if (c == 8'h59) m_rs = 1'b1;
    else if (c == 8'h58) m_caps = ~m_caps;
    else begin
      a = m_ascii(c, m_ls | m_rs, m_caps);
      if (a != 8'h00) exp_q.push_back(a);
`ifdef KB_CRLF_EN
      if (c == 8'h5A) exp_q.push_back(8'h0A);
`endif
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3, 80'h1CF01C,             1, 48'h61,     1'b0, 1'b0};
    vecs[1] = '{5, 80'h121CF0121C,         2, 48'h4161,   1'b0, 1'b0};
    vecs[2] = '{9, 80'h58F0581C121CF01216, 3, 48'h416131, 1'b0, 1'b1};
    vecs[3] = '{5, 80'h12E0F0121C,         1, 48'h41,     1'b1, 1'b0};
    vecs[4] = '{6, 80'hE075E0F0751C,       1, 48'h61,     1'b0, 1'b0};
    vecs[5] = '{4, 80'hF0F01C1C,           1, 48'h61,     1'b0, 1'b0};
`ifdef KB_CRLF_EN
    vecs[6] = '{4, 80'h290D665A,           5, 48'h2009080D0A, 1'b0, 1'b0};
`else
    vecs[6] = '{4, 80'h290D665A,           4, 48'h2009080D,   1'b0, 1'b0};
`endif
    vecs[7] = '{4, 80'h58124E52,           2, 48'h5F22,   1'b1, 1'b1};
    vecs[8] = '{3, 80'h05761C,             1, 48'h61,     1'b0, 1'b0};
    vecs[9] = '{5, 80'h592CF0592C,         2, 48'h5474,   1'b0, 1'b0};

    i_reset = 1'b0;
    push(8'h1C);
    tick();
    check("rst_scan_rd", o_scan_rd, 0);
    check("rst_tx_wr", o_tx_wr, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_shift", o_shift, 0);
    check("rst_caps", o_caps, 0);
    check("rst_no_pop", fifo.size(), 1);

    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].codes[8*(vecs[v].n-1-i) +: 8]);
      wait_drain(1'b0, 200);
      check($sformatf("v%0d_nwr", v), got.size(), vecs[v].ne);
      for (int i = 0; i < vecs[v].ne; i++)
        check($sformatf("v%0d_byte%0d", v, i), (i < got.size()) ? int'(got[i]) : -1,
              int'(vecs[v].exp[8*(vecs[v].ne-1-i) +: 8]));
      check($sformatf("v%0d_pops", v), rd_cyc.size(), vecs[v].n);
      check($sformatf("v%0d_shift", v), o_shift, vecs[v].shift);
      check($sformatf("v%0d_caps", v), o_caps, vecs[v].caps);
    end

    do_reset();
    push(8'h1C);
    push(8'h1C);
    wait_drain(1'b0, 50);
    check("latency", (got_cyc.size() > 0 && rd_cyc.size() > 0) ? got_cyc[0] - rd_cyc[0] : -1, 2);
    check("throughput", (got_cyc.size() > 1) ? got_cyc[1] - got_cyc[0] : -1, 3);

    do_reset();
    i_tx_full = 1'b1;
    push(8'h1C);
    push(8'h1C);
    for (int i = 0; i < 20 && rd_cyc.size() < 1; i++) tick();
    tick();
    tick();
    repeat (10) tick();
    check("stall_no_pop", rd_cyc.size(), 1);
    check("stall_no_wr", got.size(), 0);
    i_tx_full = 1'b0;
    tick();
    check("stall_release_wr", got.size(), 1);
    check("stall_release_data", (got.size() > 0) ? int'(got[0]) : -1, 8'h61);
    wait_drain(1'b0, 50);
    check("stall_total_wr", got.size(), 2);

    do_reset();
    push(8'h5A);
    wait_drain(1'b0, 50);
`ifdef KB_CRLF_EN
    check("crlf_nwr", got.size(), 2);
    check("crlf_lf", (got.size() > 1) ? int'(got[1]) : -1, 8'h0A);
    check("crlf_b2b", (got_cyc.size() > 1) ? got_cyc[1] - got_cyc[0] : -1, 1);
`else
    check("cr_nwr", got.size(), 1);
    check("cr_byte", (got.size() > 0) ? int'(got[0]) : -1, 8'h0D);
`endif

    do_reset();
    push(8'h12);
    wait_drain(1'b0, 50);
    check("shift_make", o_shift, 1);
    push(8'hF0);
    push(8'h12);
    wait_drain(1'b0, 50);
    check("shift_break", o_shift, 0);
    check("shift_no_wr", got.size(), 0);

    do_reset();
    push(8'h12);
    wait_drain(1'b0, 50);
    i_tx_full = 1'b1;
    push(8'h1C);
    for (int i = 0; i < 20 && rd_cyc.size() < 2; i++) tick();
    tick();
    tick();
    i_tx_full = 1'b0;
    #1;
    check("mid_emit_wr_pre", o_tx_wr, 1);
    #2;
    i_reset = 1'b0;
    #1;
    check("mid_rst_tx_wr", o_tx_wr, 0);
    check("mid_rst_tx_data", o_tx_data, 0);
    check("mid_rst_shift", o_shift, 0);
    check("mid_rst_caps", o_caps, 0);
    check("mid_rst_scan_rd", o_scan_rd, 0);
    tick();
    tick();
    got.delete();
    i_reset = 1'b1;
    push(8'h1C);
    wait_drain(1'b0, 50);
    check("post_rst_nwr", got.size(), 1);
    check("post_rst_byte", (got.size() > 0) ? int'(got[0]) : -1, 8'h61);

    do_reset();
    {m_brk, m_ext, m_ls, m_rs, m_caps} = '0;
    exp_q.delete();
    for (int k = 0; k < 200; k++) begin
      logic [7:0] c;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: c = LC[$urandom_range(0, 25)];
        4:          c = DC[$urandom_range(0, 9)];
        5:          c = SC[$urandom_range(0, 10)];
        6:          c = 8'hF0;
        7:          c = 8'hE0;
        default:    c = MISC[$urandom_range(0, 9)];
      endcase
      fifo.push_back(c);
      model_step(c);
    end
    drive();
    wait_drain(1'b1, 5000);
    check("rnd_nwr", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rnd_byte%0d", i), (i < got.size()) ? int'(got[i]) : -1, int'(exp_q[i]));
    check("rnd_shift", o_shift, m_ls | m_rs);
    check("rnd_caps", o_caps, m_caps);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
